// File: rtl/hazard_pkg.sv
// Shared types and constants for the semiMIPS hazard/halt controller and ctrlsigmux.
// State encodings are fixed so the state register can be probed in waveforms by value.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        HALT  = 2'b10
    } state_e;

    // Select values for ctrlsigmux: live control signals or a NOP bubble.
    localparam logic SEL_CTRL = 1'b0;
    localparam logic SEL_NOP  = 1'b1;

endpackage

// File: rtl/satcounter.sv
// Parameterised saturating up-counter with asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module satcounter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard and halt controller: load-use stalls, MEM-resolved branch flushes,
// and a counted pipeline drain after fin before reporting halted.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAINCYC = 3,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      idrs,
    input  logic [4:0]      idrt,
    input  logic            idusers,
    input  logic            idusert,
    input  logic            idfin,
    input  logic            exmemrd,
    input  logic [4:0]      exwreg,
    input  logic            memtaken,
    output logic            ctrlsig,
    output logic            pcwr,
    output logic            ifidwr,
    output logic            ifidflush,
    output logic            exmemflush,
    output logic            halted,
    output logic [CNTW-1:0] stallcnt
);

    localparam int DCW = (DRAINCYC < 1) ? 1 : $clog2(DRAINCYC + 1);

    state_e         state_q, state_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           halted_q;
    logic           lu;
    logic           count_lu;

    // Register 0 is hard-wired, so a load targeting it never creates a real dependency.
    assign lu = exmemrd && (exwreg != 5'd0) &&
                ((idusers && (exwreg == idrs)) || (idusert && (exwreg == idrt)));

    // NOTE: every output and next-state is given a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        ctrlsig    = SEL_CTRL;
        pcwr       = 1'b1;
        ifidwr     = 1'b1;
        ifidflush  = 1'b0;
        exmemflush = 1'b0;
        count_lu   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (memtaken) begin
                    ctrlsig    = SEL_NOP;
                    ifidflush  = 1'b1;
                    exmemflush = 1'b1;
                end else if (lu) begin
                    ctrlsig  = SEL_NOP;
                    pcwr     = 1'b0;
                    ifidwr   = 1'b0;
                    count_lu = 1'b1;
                end else if (idfin) begin
                    pcwr    = 1'b0;
                    ifidwr  = 1'b0;
                    state_d = DRAIN;
                    dcnt_d  = DCW'(DRAINCYC);
                end
            end

            DRAIN: begin
                if (memtaken) begin
                    // fin turned out to be on the wrong path: flush it and resume fetching.
                    ctrlsig    = SEL_NOP;
                    ifidflush  = 1'b1;
                    exmemflush = 1'b1;
                    state_d    = RUN;
                    dcnt_d     = '0;
                end else begin
                    ctrlsig = SEL_NOP;
                    pcwr    = 1'b0;
                    ifidwr  = 1'b0;
                    dcnt_d  = dcnt_q - DCW'(1);
                    if (dcnt_q <= DCW'(1)) begin
                        state_d = HALT;
                    end
                end
            end

            HALT: begin
                ctrlsig = SEL_NOP;
                pcwr    = 1'b0;
                ifidwr  = 1'b0;
            end

            default: begin
                state_d = RUN;
                dcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            dcnt_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            halted_q <= (state_d == HALT);
        end
    end

    assign halted = halted_q;

    satcounter #(
        .W(CNTW)
    ) u_stallcnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (count_lu),
        .cnt_o (stallcnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a RUN-state vector table plus hand-written
// drain, wrong-path-fin, halt/reset and counter-saturation sequences.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] idrs, idrt, exwreg;
    logic       idusers, idusert, idfin, exmemrd, memtaken;

    logic        ctrlsig, pcwr, ifidwr, ifidflush, exmemflush, halted;
    logic [15:0] stallcnt;
    logic        ctrlsig2, pcwr2, ifidwr2, ifidflush2, exmemflush2, halted2;
    logic [1:0]  stallcnt2;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAINCYC(3), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .idrs(idrs), .idrt(idrt), .idusers(idusers),
        .idusert(idusert), .idfin(idfin), .exmemrd(exmemrd), .exwreg(exwreg),
        .memtaken(memtaken), .ctrlsig(ctrlsig), .pcwr(pcwr), .ifidwr(ifidwr),
        .ifidflush(ifidflush), .exmemflush(exmemflush), .halted(halted),
        .stallcnt(stallcnt)
    );

    // Narrow-counter instance, used to observe saturation.
    hazard_ctrl #(.DRAINCYC(3), .CNTW(2)) u_dut2 (
        .clk(clk), .rst(rst), .idrs(idrs), .idrt(idrt), .idusers(idusers),
        .idusert(idusert), .idfin(idfin), .exmemrd(exmemrd), .exwreg(exwreg),
        .memtaken(memtaken), .ctrlsig(ctrlsig2), .pcwr(pcwr2), .ifidwr(ifidwr2),
        .ifidflush(ifidflush2), .exmemflush(exmemflush2), .halted(halted2),
        .stallcnt(stallcnt2)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       users;
        logic       usert;
        logic       fin;
        logic       memrd;
        logic [4:0] wreg;
        logic       taken;
        logic       e_ctrl;
        logic       e_pcwr;
        logic       e_ifidwr;
        logic       e_iff;
        logic       e_emf;
        logic       e_inc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic users,
                         input logic usert, input logic fin, input logic memrd,
                         input logic [4:0] wreg, input logic taken);
        idrs = rs; idrt = rt; idusers = users; idusert = usert;
        idfin = fin; exmemrd = memrd; exwreg = wreg; memtaken = taken;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic check_mealy(input string tag, input logic c, input logic p, input logic w,
                               input logic f1, input logic f2);
        check({tag, " ctrlsig"}, 32'(ctrlsig), 32'(c));
        check({tag, " pcwr"}, 32'(pcwr), 32'(p));
        check({tag, " ifidwr"}, 32'(ifidwr), 32'(w));
        check({tag, " ifidflush"}, 32'(ifidflush), 32'(f1));
        check({tag, " exmemflush"}, 32'(exmemflush), 32'(f2));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        #2;
        check("reset halted", 32'(halted), 32'd0);
        check("reset stallcnt", 32'(stallcnt), 32'd0);
        check("reset stallcnt2", 32'(stallcnt2), 32'd0);
        check_mealy("reset", SEL_CTRL, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_cnt = 0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // rs, rt, users, usert, fin, memrd, wreg, taken | ctrl, pcwr, ifidwr, iff, emf, inc
        vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{5'd3,  5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5'd3,  5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{5'd5,  5'd6,  1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{5'd31, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{5'd4,  5'd4,  1'b1, 1'b1, 1'b1, 1'b1, 5'd4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        idle();
        #1;
        do_reset();

        // RUN-state vectors: each applied for one cycle, Mealy outputs checked mid-cycle.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].users, vecs[i].usert,
                  vecs[i].fin, vecs[i].memrd, vecs[i].wreg, vecs[i].taken);
            @(negedge clk);
            check_mealy($sformatf("v%0d", i), vecs[i].e_ctrl, vecs[i].e_pcwr,
                        vecs[i].e_ifidwr, vecs[i].e_iff, vecs[i].e_emf);
            next_cycle();
            exp_cnt += int'(vecs[i].e_inc);
            check($sformatf("v%0d stallcnt", i), 32'(stallcnt), 32'(exp_cnt));
            check($sformatf("v%0d halted", i), 32'(halted), 32'd0);
        end
        // Fin arriving after a taken branch or under lu must not have started a drain.
        idle();
        @(negedge clk);
        check_mealy("post-table idle", SEL_CTRL, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();

        // fin issues, three bubbles follow, then halted holds; lu in DRAIN/HALT is not counted.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check_mealy("fin issue", SEL_CTRL, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        for (int k = 1; k <= 3; k++) begin
            drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
            @(negedge clk);
            check_mealy($sformatf("drain%0d", k), SEL_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("drain%0d halted", k), 32'(halted), 32'd0);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
            @(negedge clk);
            check($sformatf("halt%0d halted", k), 32'(halted), 32'd1);
            check_mealy($sformatf("halt%0d", k), SEL_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        check("halt stallcnt frozen", 32'(stallcnt), 32'(exp_cnt));

        // Asynchronous reset from HALT, mid-cycle.
        #2;
        do_reset();

        // Wrong-path fin: taken branch during DRAIN returns to RUN.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_mealy("abort drain", SEL_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        check_mealy("abort flush", SEL_NOP, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        idle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_mealy($sformatf("abort run%0d", k), SEL_CTRL, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("abort run%0d halted", k), 32'(halted), 32'd0);
            next_cycle();
        end

        // Back-to-back lu stalls: 2-bit counter saturates at 3, 16-bit keeps counting.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
            next_cycle();
            check($sformatf("sat%0d stallcnt2", k), 32'(stallcnt2), 32'((k > 3) ? 3 : k));
            check($sformatf("sat%0d stallcnt", k), 32'(stallcnt), 32'(k));
        end
        idle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
